// File: rtl/aes_pkg.sv
// Shared definitions for the AES round controller: key-size encodings,
// round counts, FSM state encoding and the round-key index helper.
package aes_pkg;

    typedef enum logic [1:0] {
        KS_128 = 2'b00,
        KS_192 = 2'b01,
        KS_256 = 2'b10,
        KS_BAD = 2'b11
    } key_size_t;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [3:0] nr_of(input logic [1:0] ks);
        logic [3:0] n;
        case (key_size_t'(ks))
            KS_192:  n = NR_192;
            KS_256:  n = NR_256;
            default: n = NR_128;
        endcase
        return n;
    endfunction

    // The inverse cipher walks the expanded schedule from the top down.
    function automatic logic [3:0] rk_index(input logic       dec,
                                            input logic [3:0] nr,
                                            input logic [3:0] rnd);
        return dec ? (nr - rnd) : rnd;
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: steps INIT, ROUND 1..nr-1, FINAL, DONE for one block
// and drives registered round/round-key controls to the datapath.
module aes_round_ctrl
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       decrypt,
    input  logic [1:0] key_size,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] nr,
    output logic [3:0] round,
    output logic [3:0] rk_sel,
    output logic       load,
    output logic       first,
    output logic       last,
    output logic       dec_mode,
    output state_t     dbg_state
);

    // Handshake: start is a level sampled on the rising edge; it is acted on
    // only when the controller is in IDLE or DONE and abort is low that edge.
    // done and err are single-cycle pulses; busy covers INIT..FINAL.

    state_t     r_state;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic [3:0] r_nr;
    logic [3:0] r_round;
    logic [3:0] r_rk_sel;
    logic       r_load;
    logic       r_first;
    logic       r_last;
    logic       r_dec;

    logic       w_start_ok;
    logic       w_ks_bad;
    logic [3:0] w_nr_new;
    logic [3:0] w_round_nx;

    assign w_start_ok = start & ~abort;
    assign w_ks_bad   = (key_size_t'(key_size) == KS_BAD);
    assign w_nr_new   = nr_of(key_size);
    assign w_round_nx = r_round + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_nr     <= NR_128;
            r_round  <= 4'd0;
            r_rk_sel <= 4'd0;
            r_load   <= 1'b0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_dec    <= 1'b0;
        end else begin
            // Anything not overridden below falls back to the idle picture.
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_round  <= 4'd0;
            r_rk_sel <= 4'd0;
            r_load   <= 1'b0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        if (w_ks_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state  <= S_INIT;
                            r_nr     <= w_nr_new;
                            r_dec    <= decrypt;
                            r_busy   <= 1'b1;
                            r_load   <= 1'b1;
                            r_first  <= 1'b1;
                            r_rk_sel <= rk_index(decrypt, w_nr_new, 4'd0);
                        end
                    end
                end
                S_INIT, S_ROUND: begin
                    if (!abort) begin
                        r_busy   <= 1'b1;
                        r_round  <= w_round_nx;
                        r_rk_sel <= rk_index(r_dec, r_nr, w_round_nx);
                        if (w_round_nx == r_nr) begin
                            r_state <= S_FINAL;
                            r_last  <= 1'b1;
                        end else begin
                            r_state <= S_ROUND;
                        end
                    end
                end
                S_FINAL: begin
                    if (!abort) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign nr        = r_nr;
    assign round     = r_round;
    assign rk_sel    = r_rk_sel;
    assign load      = r_load;
    assign first     = r_first;
    assign last      = r_last;
    assign dec_mode  = r_dec;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: a cycle-count model of one block operation is
// compared against the DUT every cycle, plus directed literal checks.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       decrypt = 1'b0;
  logic [1:0] key_size = 2'b00;
  logic       abort = 1'b0;
  logic       busy, done, err, load, first, last, dec_mode;
  logic [3:0] nr, round, rk_sel;
  state_t     dbg_state;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt),
    .key_size(key_size), .abort(abort), .busy(busy), .done(done),
    .err(err), .nr(nr), .round(round), .rk_sel(rk_sel), .load(load),
    .first(first), .last(last), .dec_mode(dec_mode), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- model: time since the accepted start ----------------
  // m_t = 1 is the INIT cycle, m_t = nr+2 is the DONE cycle.
  bit m_active = 1'b0;
  int m_t      = 0;
  int m_nr     = 10;
  bit m_dec    = 1'b0;
  bit m_err    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0; m_t = 0; m_nr = 10; m_dec = 1'b0; m_err = 1'b0;
    end else begin
      cyc++;
      m_err = 1'b0;
      if (m_active && m_t <= m_nr + 1) begin
        if (abort) m_active = 1'b0;
        else m_t++;
      end else begin
        m_active = 1'b0;
        if (start && !abort) begin
          if (key_size == 2'b11) m_err = 1'b1;
          else begin
            m_active = 1'b1; m_t = 1;
            m_nr = 10 + 2 * int'(key_size);
            m_dec = decrypt;
          end
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  bit e_busy, e_done;
  int e_round, e_rk;

  always @(negedge clk) begin
    if (chk_en) begin
      e_busy  = m_active && (m_t <= m_nr + 1);
      e_done  = m_active && (m_t == m_nr + 2);
      e_round = e_busy ? m_t - 1 : 0;
      e_rk    = !e_busy ? 0 : (m_dec ? m_nr - e_round : e_round);
      check("busy",     busy,     e_busy);
      check("done",     done,     e_done);
      check("err",      err,      m_err);
      check("nr",       nr,       m_nr);
      check("dec_mode", dec_mode, m_dec);
      check("round",    round,    e_round);
      check("rk_sel",   rk_sel,   e_rk);
      check("load",     load,     e_busy && m_t == 1);
      check("first",    first,    e_busy && m_t == 1);
      check("last",     last,     e_busy && m_t == m_nr + 1);
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the cycle index (INIT = 1) at which done is seen.
  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run_block(input logic [1:0] ks, input logic dec,
                           input int exp_lat, input int exp_rk0, input int exp_nr);
    int n;
    key_size = ks; decrypt = dec; start = 1'b1;
    tick();
    start = 1'b0;
    check("init_first",  first,  1);
    check("init_load",   load,   1);
    check("init_rk_sel", rk_sel, exp_rk0);
    check("init_nr",     nr,     exp_nr);
    wait_done(n);
    check("done_latency", n, exp_lat);
    tick();
    check("after_done_busy", busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  int n, d0;

  initial begin
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    tick();
    check("rst_busy",  busy, 0);
    check("rst_nr",    nr, 10);
    check("rst_state", dbg_state, S_IDLE);
    tick();
    rst = 1'b0;
    tick();

    // 128-bit cipher, then 256-bit inverse cipher
    run_block(2'b00, 1'b0, 12, 0, 10);
    run_block(2'b10, 1'b1, 16, 14, 14);

    // illegal key size: err pulse only, nr keeps its last value
    key_size = 2'b11; start = 1'b1;
    d0 = done_cnt;
    tick();
    start = 1'b0;
    check("bad_err",  err, 1);
    check("bad_busy", busy, 0);
    check("bad_nr",   nr, 14);
    tick();
    check("bad_err_clear", err, 0);
    repeat (18) tick();
    check("bad_no_done", done_cnt, d0);

    // 192-bit back-to-back: restart on the DONE cycle
    key_size = 2'b01; decrypt = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("b2b_lat1", n, 14);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_first", first, 1);
    check("b2b_busy",  busy, 1);
    wait_done(n);
    check("b2b_lat2", n, 14);
    tick();

    // abort at round 5; a start during busy is ignored
    key_size = 2'b00; decrypt = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (round != 4'd3 && n < 20) begin tick(); n++; end
    check("abort_reach3", round, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ignored", round, 4);
    tick();
    check("abort_reach5", round, 5);
    d0 = done_cnt;
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_busy",  busy, 0);
    check("abort_round", round, 0);
    check("abort_state", dbg_state, S_IDLE);
    repeat (16) tick();
    check("abort_no_done", done_cnt, d0);

    // asynchronous reset mid-ROUND
    key_size = 2'b01; decrypt = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    d0 = done_cnt;
    #1 rst = 1'b1;
    #1;
    check("arst_busy",     busy, 0);
    check("arst_round",    round, 0);
    check("arst_rk_sel",   rk_sel, 0);
    check("arst_nr",       nr, 10);
    check("arst_dec_mode", dec_mode, 0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_no_done", done_cnt, d0);
    run_block(2'b00, 1'b1, 12, 10, 10);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
